// File: rtl/vscale_tohost_monitor.sv
// Synthesizable tohost pass/fail monitor: snoops dmem stores to a bank of tohost
// mailboxes, tracks a saturating cycle count and reports a sticky verdict.
module vscale_tohost_monitor #(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    NUM_CHANNELS   = 2,
  parameter logic [ADDR_WIDTH-1:0] TOHOST_BASE    = 32'h00001000,
  parameter int                    CHANNEL_STRIDE = 4,
  parameter int                    CYCLE_WIDTH    = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    dmem_en,
  input  logic                    dmem_wen,
  input  logic [ADDR_WIDTH-1:0]   dmem_addr,
  input  logic [DATA_WIDTH-1:0]   dmem_wdata_delayed,
  input  logic [CYCLE_WIDTH-1:0]  max_cycles,
  input  logic                    clear,
  output logic                    done,
  output logic                    passed,
  output logic                    failed,
  output logic                    timed_out,
  output logic [DATA_WIDTH-2:0]   fail_code,
  output logic [2:0]              fail_channel,
  output logic [NUM_CHANNELS-1:0] chan_passed,
  output logic [CYCLE_WIDTH-1:0]  cycle_count
);

  typedef enum logic [1:0] {
    S_RUN,
    S_PASSED,
    S_FAILED,
    S_TIMEOUT
  } state_t;

  state_t                  state_q, state_d;
  logic                    hit_valid_q;
  logic [2:0]              hit_chan_q;
  logic                    addr_hit;
  logic [2:0]              addr_chan;
  logic [NUM_CHANNELS-1:0] chan_passed_q, chan_passed_d;
  logic [NUM_CHANNELS-1:0] pass_mask;
  logic [DATA_WIDTH-2:0]   fail_code_q, fail_code_d;
  logic [2:0]              fail_channel_q, fail_channel_d;
  logic [CYCLE_WIDTH-1:0]  cycle_count_q, cnt_next;
  logic                    timeout_hit;
  logic                    data_is_one;
  logic                    data_is_fail;

  always_comb begin
    addr_hit  = 1'b0;
    addr_chan = '0;
    if (dmem_en && dmem_wen) begin
      for (int k = 0; k < NUM_CHANNELS; k++) begin
        if (dmem_addr == TOHOST_BASE + ADDR_WIDTH'(k * CHANNEL_STRIDE)) begin
          addr_hit  = 1'b1;
          addr_chan = 3'(k);
        end
      end
    end
  end

  // Timeout is judged against the count being written on this edge, so the
  // verdict appears together with the first count above the limit.
  assign cnt_next     = (cycle_count_q == '1) ? cycle_count_q : cycle_count_q + CYCLE_WIDTH'(1);
  assign timeout_hit  = (max_cycles != '0) && (cnt_next > max_cycles);
  assign data_is_one  = (dmem_wdata_delayed == DATA_WIDTH'(1));
  assign data_is_fail = (dmem_wdata_delayed != '0) && !data_is_one;
  assign pass_mask    = chan_passed_q |
                        ((hit_valid_q && data_is_one) ? (NUM_CHANNELS'(1) << hit_chan_q) : '0);

  always_comb begin
    state_d        = state_q;
    chan_passed_d  = chan_passed_q;
    fail_code_d    = fail_code_q;
    fail_channel_d = fail_channel_q;
    if (state_q == S_RUN) begin
      if (hit_valid_q && data_is_fail) begin
        state_d        = S_FAILED;
        fail_code_d    = dmem_wdata_delayed[DATA_WIDTH-1:1];
        fail_channel_d = hit_chan_q;
      end else begin
        chan_passed_d = pass_mask;
        if (pass_mask == {NUM_CHANNELS{1'b1}}) begin
          state_d = S_PASSED;
        end else if (timeout_hit) begin
          state_d = S_TIMEOUT;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_RUN;
      hit_valid_q    <= 1'b0;
      hit_chan_q     <= '0;
      chan_passed_q  <= '0;
      fail_code_q    <= '0;
      fail_channel_q <= '0;
      cycle_count_q  <= '0;
    end else if (clear) begin
      state_q        <= S_RUN;
      hit_valid_q    <= 1'b0;
      hit_chan_q     <= '0;
      chan_passed_q  <= '0;
      fail_code_q    <= '0;
      fail_channel_q <= '0;
      cycle_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      hit_valid_q    <= addr_hit;
      hit_chan_q     <= addr_chan;
      chan_passed_q  <= chan_passed_d;
      fail_code_q    <= fail_code_d;
      fail_channel_q <= fail_channel_d;
      cycle_count_q  <= cnt_next;
    end
  end

  assign done         = (state_q != S_RUN);
  assign passed       = (state_q == S_PASSED);
  assign failed       = (state_q == S_FAILED);
  assign timed_out    = (state_q == S_TIMEOUT);
  assign fail_code    = fail_code_q;
  assign fail_channel = fail_channel_q;
  assign chan_passed  = chan_passed_q;
  assign cycle_count  = cycle_count_q;

endmodule

// File: tb/tb_vscale_tohost_monitor.sv
// Directed bench for vscale_tohost_monitor: a two-channel instance plus a
// single-channel instance sharing the same dmem stimulus.
module tb_vscale_tohost_monitor;

  logic        clk;
  logic        reset;
  logic        dmem_en;
  logic        dmem_wen;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata_delayed;
  logic [63:0] max_cycles;
  logic        clear;

  logic        done, passed, failed, timed_out;
  logic [30:0] fail_code;
  logic [2:0]  fail_channel;
  logic [1:0]  chan_passed;
  logic [63:0] cycle_count;

  logic        one_done, one_passed, one_failed, one_timed_out;
  logic [30:0] one_fail_code;
  logic [2:0]  one_fail_channel;
  logic [0:0]  one_chan_passed;
  logic [63:0] one_cycle_count;

  int checks = 0;
  int errors = 0;

  vscale_tohost_monitor #(.NUM_CHANNELS(2)) dut (
    .clk(clk), .reset(reset), .dmem_en(dmem_en), .dmem_wen(dmem_wen),
    .dmem_addr(dmem_addr), .dmem_wdata_delayed(dmem_wdata_delayed),
    .max_cycles(max_cycles), .clear(clear), .done(done), .passed(passed),
    .failed(failed), .timed_out(timed_out), .fail_code(fail_code),
    .fail_channel(fail_channel), .chan_passed(chan_passed), .cycle_count(cycle_count)
  );

  vscale_tohost_monitor #(.NUM_CHANNELS(1)) u_one (
    .clk(clk), .reset(reset), .dmem_en(dmem_en), .dmem_wen(dmem_wen),
    .dmem_addr(dmem_addr), .dmem_wdata_delayed(dmem_wdata_delayed),
    .max_cycles(max_cycles), .clear(clear), .done(one_done), .passed(one_passed),
    .failed(one_failed), .timed_out(one_timed_out), .fail_code(one_fail_code),
    .fail_channel(one_fail_channel), .chan_passed(one_chan_passed),
    .cycle_count(one_cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Address phase now, data phase next cycle; returns one sample after the
  // edge that ends the data phase.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data);
    dmem_en   = 1'b1;
    dmem_wen  = 1'b1;
    dmem_addr = addr;
    @(posedge clk); #1;
    dmem_en            = 1'b0;
    dmem_wen           = 1'b0;
    dmem_wdata_delayed = data;
    @(posedge clk); #1;
  endtask

  task automatic pulseClear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  task automatic waitCount(input logic [63:0] target);
    int n = 0;
    while (cycle_count !== target && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("wait_count_reached", cycle_count, target);
  endtask

  initial begin
    reset = 1'b0; dmem_en = 1'b0; dmem_wen = 1'b0; dmem_addr = '0;
    dmem_wdata_delayed = '0; max_cycles = '0; clear = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_done", {63'd0, done}, 64'd0);
    checkOutput("rst_status", {61'd0, passed, failed, timed_out}, 64'd0);
    checkOutput("rst_fail_code", {33'd0, fail_code}, 64'd0);
    checkOutput("rst_fail_channel", {61'd0, fail_channel}, 64'd0);
    checkOutput("rst_chan_passed", {62'd0, chan_passed}, 64'd0);
    checkOutput("rst_cycle_count", cycle_count, 64'd0);

    reset = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    checkOutput("count_after_3", cycle_count, 64'd3);

    // Single-channel pass with latency check: nothing visible one edge in.
    dmem_en = 1'b1; dmem_wen = 1'b1; dmem_addr = 32'h1000;
    @(posedge clk); #1;
    checkOutput("one_latency_done", {63'd0, one_done}, 64'd0);
    dmem_en = 1'b0; dmem_wen = 1'b0; dmem_wdata_delayed = 32'd1;
    @(posedge clk); #1;
    checkOutput("one_passed", {63'd0, one_passed}, 64'd1);
    checkOutput("one_done", {63'd0, one_done}, 64'd1);
    checkOutput("one_fail_code", {33'd0, one_fail_code}, 64'd0);
    checkOutput("two_chan_partial", {62'd0, chan_passed}, 64'd1);
    checkOutput("two_not_passed", {63'd0, passed}, 64'd0);

    repeat (10) @(posedge clk);
    #1;
    checkOutput("two_still_partial", {62'd0, chan_passed}, 64'd1);
    applyStimulus(32'h1004, 32'd1);
    checkOutput("two_passed", {63'd0, passed}, 64'd1);
    checkOutput("two_chan_all", {62'd0, chan_passed}, 64'd3);
    checkOutput("two_done", {63'd0, done}, 64'd1);

    pulseClear();
    checkOutput("clr1_status", {60'd0, done, passed, failed, timed_out}, 64'd0);
    checkOutput("clr1_chan", {62'd0, chan_passed}, 64'd0);
    checkOutput("clr1_count", cycle_count, 64'd0);

    applyStimulus(32'h1004, 32'h2B);
    checkOutput("fail_flag", {63'd0, failed}, 64'd1);
    checkOutput("fail_code", {33'd0, fail_code}, 64'h15);
    checkOutput("fail_channel", {61'd0, fail_channel}, 64'd1);
    applyStimulus(32'h1000, 32'd1);
    checkOutput("fail_sticky", {60'd0, done, passed, failed, timed_out}, 64'b1010);
    checkOutput("fail_frozen_chan", {62'd0, chan_passed}, 64'd0);
    checkOutput("fail_frozen_code", {33'd0, fail_code}, 64'h15);

    pulseClear();
    checkOutput("clr2_status", {60'd0, done, passed, failed, timed_out}, 64'd0);
    checkOutput("clr2_code", {33'd0, fail_code}, 64'd0);
    checkOutput("clr2_channel", {61'd0, fail_channel}, 64'd0);
    checkOutput("clr2_count", cycle_count, 64'd0);
    repeat (3) begin @(posedge clk); #1; end
    checkOutput("clr2_recount", cycle_count, 64'd3);

    // clear on the data-phase edge of a failing store wins.
    dmem_en = 1'b1; dmem_wen = 1'b1; dmem_addr = 32'h1004;
    @(posedge clk); #1;
    dmem_en = 1'b0; dmem_wen = 1'b0; dmem_wdata_delayed = 32'd2; clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    checkOutput("clr_override_failed", {63'd0, failed}, 64'd0);
    checkOutput("clr_override_count", cycle_count, 64'd0);

    // Back-to-back stores: ch0 data 1, then ch1 data 6.
    dmem_en = 1'b1; dmem_wen = 1'b1; dmem_addr = 32'h1000;
    @(posedge clk); #1;
    dmem_addr = 32'h1004; dmem_wdata_delayed = 32'd1;
    @(posedge clk); #1;
    checkOutput("b2b_first_chan", {62'd0, chan_passed}, 64'd1);
    checkOutput("b2b_first_failed", {63'd0, failed}, 64'd0);
    dmem_en = 1'b0; dmem_wen = 1'b0; dmem_wdata_delayed = 32'd6;
    @(posedge clk); #1;
    checkOutput("b2b_failed", {63'd0, failed}, 64'd1);
    checkOutput("b2b_fail_code", {33'd0, fail_code}, 64'd3);
    checkOutput("b2b_fail_channel", {61'd0, fail_channel}, 64'd1);

    pulseClear();
    applyStimulus(32'h1000, 32'd0);
    applyStimulus(32'h1008, 32'd1);
    dmem_en = 1'b1; dmem_wen = 1'b0; dmem_addr = 32'h1004;
    @(posedge clk); #1;
    dmem_en = 1'b0; dmem_wdata_delayed = 32'd5;
    @(posedge clk); #1;
    checkOutput("ignore_status", {60'd0, done, passed, failed, timed_out}, 64'd0);
    checkOutput("ignore_chan", {62'd0, chan_passed}, 64'd0);
    checkOutput("ignore_count", cycle_count, 64'd6);

    max_cycles = 64'd50;
    pulseClear();
    waitCount(64'd50);
    checkOutput("to_not_yet", {63'd0, timed_out}, 64'd0);
    @(posedge clk); #1;
    checkOutput("to_flag", {60'd0, done, passed, failed, timed_out}, 64'b1001);
    checkOutput("to_count", cycle_count, 64'd51);
    applyStimulus(32'h1000, 32'd2);
    checkOutput("to_frozen", {60'd0, done, passed, failed, timed_out}, 64'b1001);
    checkOutput("to_count_runs", cycle_count, 64'd53);

    // Pass whose data phase lands on the timeout edge beats the timeout.
    pulseClear();
    applyStimulus(32'h1000, 32'd1);
    checkOutput("race_partial", {62'd0, chan_passed}, 64'd1);
    waitCount(64'd49);
    dmem_en = 1'b1; dmem_wen = 1'b1; dmem_addr = 32'h1004;
    @(posedge clk); #1;
    dmem_en = 1'b0; dmem_wen = 1'b0; dmem_wdata_delayed = 32'd1;
    @(posedge clk); #1;
    checkOutput("race_status", {60'd0, done, passed, failed, timed_out}, 64'b1100);
    checkOutput("race_count", cycle_count, 64'd51);

    // Reset pulse between address and data phase discards the pending hit.
    max_cycles = 64'd0;
    pulseClear();
    dmem_en = 1'b1; dmem_wen = 1'b1; dmem_addr = 32'h1004;
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    checkOutput("midrst_count", cycle_count, 64'd0);
    checkOutput("midrst_done", {63'd0, done}, 64'd0);
    #1;
    reset = 1'b1; dmem_en = 1'b0; dmem_wen = 1'b0; dmem_wdata_delayed = 32'd9;
    @(posedge clk); #1;
    checkOutput("midrst_no_verdict", {60'd0, done, passed, failed, timed_out}, 64'd0);
    checkOutput("midrst_fail_code", {33'd0, fail_code}, 64'd0);
    checkOutput("midrst_count_after", cycle_count, 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vscale_tohost_monitor.md
Name: vscale_tohost_monitor

Overview:
- Synthesizable, multi-channel successor to the simulation-only tohost pass/fail checker.
- Snoops the vscale core data-memory port for stores to NUM_CHANNELS tohost mailbox addresses and tracks a 64-bit cycle count with an optional timeout.
- Reports a sticky PASSED/FAILED/TIMEOUT verdict with failing code and channel.
- Used in chip-level sims and FPGA builds in place of bench-side $display/$finish logic.

Parameters:
- ADDR_WIDTH, 32, dmem address width.
- DATA_WIDTH, 32, dmem write-data width.
- NUM_CHANNELS, 2, number of tohost mailboxes (1..8).
- TOHOST_BASE, 32'h00001000, address of channel 0 mailbox.
- CHANNEL_STRIDE, 4, byte offset between consecutive mailboxes.
- CYCLE_WIDTH, 64, width of cycle counter and max_cycles.

Ports:
- clk  input  1  core clock.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- dmem_en  input  1  dmem request valid (address phase).
- dmem_wen  input  1  dmem request is a store.
- dmem_addr  input  ADDR_WIDTH  dmem request address.
- dmem_wdata_delayed  input  DATA_WIDTH  store data; valid one cycle after the address phase.
- max_cycles  input  CYCLE_WIDTH  timeout limit; 0 disables timeout.
- clear  input  1  synchronous restart of monitor to RUN.
- done  output  1  verdict reached (sticky).
- passed  output  1  all channels reported 1.
- failed  output  1  some channel reported an odd value other than 1, or an even nonzero value.
- timed_out  output  1  cycle limit exceeded.
- fail_code  output  DATA_WIDTH-1  tohost value >> 1 of the failing write.
- fail_channel  output  3  index of failing channel.
- chan_passed  output  NUM_CHANNELS  per-channel pass mask.
- cycle_count  output  CYCLE_WIDTH  cycles since reset/clear.

Behaviour:
- Reset (reset==0, async): state=RUN. All outputs 0. cycle_count=0.
- Address phase, cycle N:
  - hit = dmem_en & dmem_wen & (dmem_addr == TOHOST_BASE + k*CHANNEL_STRIDE) for some k < NUM_CHANNELS.
  - Register hit_valid and hit_chan.
- Data phase, cycle N+1: if hit_valid, sample dmem_wdata_delayed as v.
  - v==0: ignored.
  - v==1: set chan_passed[k].
  - Any other value: fail event.
- Outputs update on the clk edge ending cycle N+1 and are visible in cycle N+2 (2-cycle latency from address phase).
- Back-to-back stores in N and N+1 are both processed; the hit register is pipelined and is not blocked.
- State machine: RUN, PASSED, FAILED, TIMEOUT. PASSED/FAILED/TIMEOUT are terminal until reset or clear.
  - RUN -> FAILED on a fail event. fail_code = v[DATA_WIDTH-1:1]; fail_channel = k.
  - RUN -> PASSED when chan_passed becomes all-ones, including the same-edge update.
  - RUN -> TIMEOUT when max_cycles != 0 and cycle_count > max_cycles.
- Priority within one edge: FAILED > PASSED > TIMEOUT. A data-phase event on the timeout edge wins.
- Duplicate pass writes to an already-passed channel: no effect.
- Once done=1: all stores ignored and status frozen; cycle_count keeps counting.
- Output encoding: done = (state != RUN); passed/failed/timed_out are one-hot decodes of state.
- cycle_count increments every cycle out of reset and saturates at all-ones; no wrap.
- clear=1: synchronously returns to RUN and zeroes chan_passed, fail_code, fail_channel, cycle_count, hit pipeline. clear overrides any same-cycle event.
- Reset asserted mid-transaction: pending hit discarded; all state cleared immediately.
- Address compare is exact; no byte-enable or partial-store decoding. Unused fail_channel MSBs are 0.

Test Plan:
- NUM_CHANNELS=1: store 1 to 0x1000 at cycle 10 -> passed=1, done=1 visible at cycle 12; fail_code=0.
- Store 0x2B to 0x1004 (channel 1) -> failed=1, fail_code=0x15, fail_channel=1; a later store of 1 to 0x1000 leaves the verdict unchanged.
- Channel 0 stores 1, then channel 1 stores 1 ten cycles later -> chan_passed=2'b01 after the first store; passed=1 only after the second.
- Same edge: channel 0 data phase=1 and channel 1 data phase=6 via back-to-back stores -> FAILED, fail_code=3, fail_channel=1.
- max_cycles=50, no stores -> timed_out=1 when cycle_count=51. A store of 1 whose data phase lands on that edge -> passed instead.
- Stores of 0 and to 0x1008 (out of range) -> no state change. Assert clear after a FAILED verdict -> all outputs 0, cycle_count restarts at 0. Assert reset mid-pipeline -> no verdict.
